// File: rtl/adaptive_power_controller_if.sv
// Classifier, power-estimate and clock-manager handshake signals of the power controller.
interface adaptive_power_controller_if;
  logic        classificationValid;
  logic [2:0]  workloadFormat;
  logic [3:0]  workloadConfidence;
  logic [7:0]  currentPower;
  logic [7:0]  powerBudget;
  logic        changeAck;
  logic [1:0]  powerMode;
  logic        changeRequest;
  logic [1:0]  requestedMode;
  logic        throttleActive;
  logic        requestTimeout;
  logic [15:0] modeChangeCount;
  logic [1:0]  controllerState;

  // Controller side
  modport master (
    input  classificationValid, workloadFormat, workloadConfidence,
    input  currentPower, powerBudget, changeAck,
    output powerMode, changeRequest, requestedMode, throttleActive,
    output requestTimeout, modeChangeCount, controllerState
  );

  // Classifier / clock-manager / observer side
  modport slave (
    output classificationValid, workloadFormat, workloadConfidence,
    output currentPower, powerBudget, changeAck,
    input  powerMode, changeRequest, requestedMode, throttleActive,
    input  requestTimeout, modeChangeCount, controllerState
  );
endinterface

// File: rtl/adaptive_power_controller.sv
// Adaptive power controller: filters workload classifications into a power mode and
// negotiates each mode change with the clock/voltage manager.
module adaptive_power_controller #(
  parameter int unsigned PROMOTECOUNT  = 4,
  parameter int unsigned HOLDCYCLES    = 16,
  parameter int unsigned MINCONFIDENCE = 6,
  parameter int unsigned REQTIMEOUT    = 64
) (
  input logic clk,
  input logic reset,
  adaptive_power_controller_if.master bus
);

  localparam int unsigned AGREEW = $clog2(PROMOTECOUNT + 1);
  localparam int unsigned HOLDW  = (HOLDCYCLES > 1) ? $clog2(HOLDCYCLES) : 1;
  localparam int unsigned TOW    = (REQTIMEOUT > 1) ? $clog2(REQTIMEOUT) : 1;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    REQUEST = 2'd1,
    HOLD    = 2'd2
  } ctrlState_t;

  ctrlState_t        state, stateNext;
  logic [1:0]        powerMode, powerModeNext;
  logic [1:0]        requestedMode, requestedModeNext;
  logic              changeRequest, changeRequestNext;
  logic              throttleActive;
  logic              requestTimeout, requestTimeoutNext;
  logic [15:0]       modeChangeCount, modeChangeCountNext;
  logic [AGREEW-1:0] agreeCount, agreeCountNext, agreeCalc;
  logic [1:0]        lastCandidate;
  logic [HOLDW-1:0]  holdTimer, holdTimerNext;
  logic [TOW-1:0]    timeoutTimer, timeoutTimerNext;
  logic [1:0]        mappedMode, candidate;
  logic              throttleOverride;

  function automatic logic [1:0] mapFormat(input logic [2:0] fmt);
    case (fmt)
      3'd5:       mapFormat = 2'd0;
      3'd7:       mapFormat = 2'd1;
      3'd1, 3'd6: mapFormat = 2'd3;
      default:    mapFormat = 2'd2;
    endcase
  endfunction

  // Candidate mode from the current classification, capped while over budget
  always_comb begin
    mappedMode = mapFormat(bus.workloadFormat);
    candidate  = powerMode;
    if (bus.classificationValid && (bus.workloadConfidence >= 4'(MINCONFIDENCE))) begin
      candidate = mappedMode;
      if (throttleActive && (mappedMode > 2'd1)) begin
        candidate = 2'd1;
      end
    end
    throttleOverride = throttleActive && (powerMode > 2'd1);
    if (candidate == powerMode) begin
      agreeCalc = '0;
    end else if (candidate == lastCandidate) begin
      agreeCalc = (agreeCount == AGREEW'(PROMOTECOUNT)) ? agreeCount : agreeCount + AGREEW'(1);
    end else begin
      agreeCalc = AGREEW'(1);
    end
  end

  // Next-state and next-output logic of the controller FSM
  always_comb begin
    stateNext           = state;
    powerModeNext       = powerMode;
    requestedModeNext   = requestedMode;
    changeRequestNext   = changeRequest;
    requestTimeoutNext  = 1'b0;
    modeChangeCountNext = modeChangeCount;
    agreeCountNext      = '0;
    holdTimerNext       = holdTimer;
    timeoutTimerNext    = timeoutTimer;
    case (state)
      MONITOR: begin
        agreeCountNext = agreeCalc;
        if (agreeCalc == AGREEW'(PROMOTECOUNT)) begin
          stateNext         = REQUEST;
          changeRequestNext = 1'b1;
          requestedModeNext = candidate;
          timeoutTimerNext  = '0;
          agreeCountNext    = '0;
        end else if (throttleOverride) begin
          stateNext         = REQUEST;
          changeRequestNext = 1'b1;
          requestedModeNext = 2'd1;
          timeoutTimerNext  = '0;
          agreeCountNext    = '0;
        end
      end
      REQUEST: begin
        if (bus.changeAck) begin
          stateNext         = HOLD;
          powerModeNext     = requestedMode;
          changeRequestNext = 1'b0;
          holdTimerNext     = HOLDW'(HOLDCYCLES - 1);
          if (modeChangeCount != 16'hFFFF) begin
            modeChangeCountNext = modeChangeCount + 16'd1;
          end
        end else if (timeoutTimer == TOW'(REQTIMEOUT - 1)) begin
          stateNext          = HOLD;
          changeRequestNext  = 1'b0;
          requestTimeoutNext = 1'b1;
          holdTimerNext      = HOLDW'(HOLDCYCLES - 1);
        end else begin
          timeoutTimerNext = timeoutTimer + TOW'(1);
        end
      end
      HOLD: begin
        if (throttleOverride) begin
          stateNext         = REQUEST;
          changeRequestNext = 1'b1;
          requestedModeNext = 2'd1;
          timeoutTimerNext  = '0;
        end else if (holdTimer == '0) begin
          stateNext = MONITOR;
        end else begin
          holdTimerNext = holdTimer - HOLDW'(1);
        end
      end
      default: begin
        stateNext         = MONITOR;
        changeRequestNext = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= MONITOR;
      powerMode       <= 2'd2;
      requestedMode   <= 2'd2;
      changeRequest   <= 1'b0;
      throttleActive  <= 1'b0;
      requestTimeout  <= 1'b0;
      modeChangeCount <= '0;
      agreeCount      <= '0;
      lastCandidate   <= '0;
      holdTimer       <= '0;
      timeoutTimer    <= '0;
    end else begin
      state           <= stateNext;
      powerMode       <= powerModeNext;
      requestedMode   <= requestedModeNext;
      changeRequest   <= changeRequestNext;
      throttleActive  <= (bus.currentPower > bus.powerBudget);
      requestTimeout  <= requestTimeoutNext;
      modeChangeCount <= modeChangeCountNext;
      agreeCount      <= agreeCountNext;
      lastCandidate   <= candidate;
      holdTimer       <= holdTimerNext;
      timeoutTimer    <= timeoutTimerNext;
    end
  end

  assign bus.powerMode       = powerMode;
  assign bus.changeRequest   = changeRequest;
  assign bus.requestedMode   = requestedMode;
  assign bus.throttleActive  = throttleActive;
  assign bus.requestTimeout  = requestTimeout;
  assign bus.modeChangeCount = modeChangeCount;
  assign bus.controllerState = state;

endmodule

// File: tb/tb_adaptive_power_controller.sv
// Self-checking bench for adaptive_power_controller with a request/mode scoreboard.
module tb_adaptive_power_controller;

  logic clk;
  logic reset;
  logic rstAtEdge;
  int   checkCount;
  int   errorCount;

  logic [1:0] expReq[$];
  logic [1:0] expMode[$];

  logic       prevReq;
  logic [1:0] prevMode;
  logic       prevTimeout;
  int         reqCycles;

  adaptive_power_controller_if bus();

  adaptive_power_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.classificationValid = 1'b0;
    bus.changeAck = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  // Remember whether the last edge was a reset edge
  always @(posedge clk) rstAtEdge <= reset;

  // Scoreboard monitor: pops expectations when the DUT raises a request or changes mode
  always @(negedge clk) begin
    if (!rstAtEdge) begin
      if (bus.changeRequest && !prevReq) begin
        if (expReq.size() == 0) checkValue("unexpectedRequest", 32'(bus.changeRequest), 0);
        else checkValue("requestedMode", 32'(bus.requestedMode), 32'(expReq.pop_front()));
      end
      if (bus.changeRequest) begin
        checkValue("reqDiffersFromMode", 32'(bus.requestedMode != bus.powerMode), 1);
        reqCycles++;
      end
      if (bus.powerMode != prevMode) begin
        if (expMode.size() == 0) checkValue("unexpectedModeChange", 32'(bus.powerMode), 32'(prevMode));
        else checkValue("powerModeChange", 32'(bus.powerMode), 32'(expMode.pop_front()));
      end
      if (bus.requestTimeout) checkValue("timeoutSingleCycle", 32'(prevTimeout), 0);
    end
    prevReq     = bus.changeRequest;
    prevMode    = bus.powerMode;
    prevTimeout = bus.requestTimeout;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checkCount);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    reqCycles  = 0;
    prevReq = 1'b0; prevMode = 2'd2; prevTimeout = 1'b0;
    reset = 1'b1;
    bus.classificationValid = 1'b0;
    bus.workloadFormat      = 3'd0;
    bus.workloadConfidence  = 4'd0;
    bus.currentPower        = 8'd50;
    bus.powerBudget         = 8'd200;
    bus.changeAck           = 1'b0;
    step(2);
    reset = 1'b0;

    // Reset state
    checkValue("rstPowerMode", 32'(bus.powerMode), 2);
    checkValue("rstRequestedMode", 32'(bus.requestedMode), 2);
    checkValue("rstChangeRequest", 32'(bus.changeRequest), 0);
    checkValue("rstThrottle", 32'(bus.throttleActive), 0);
    checkValue("rstTimeout", 32'(bus.requestTimeout), 0);
    checkValue("rstCount", 32'(bus.modeChangeCount), 0);
    checkValue("rstState", 32'(bus.controllerState), 0);

    // COMPUTE with good confidence promotes to PERF after four samples
    bus.classificationValid = 1'b1;
    bus.workloadFormat = 3'd1;
    bus.workloadConfidence = 4'd8;
    expReq.push_back(2'd3);
    expMode.push_back(2'd3);
    step(3);
    checkValue("noReqAfter3", 32'(bus.changeRequest), 0);
    step(1);
    checkValue("reqAfter4", 32'(bus.changeRequest), 1);
    checkValue("reqMode3", 32'(bus.requestedMode), 3);
    checkValue("stateRequest", 32'(bus.controllerState), 1);
    step(2);
    checkValue("reqHeld", 32'(bus.changeRequest), 1);
    bus.changeAck = 1'b1;
    step(1);
    bus.changeAck = 1'b0;
    checkValue("ackPowerMode", 32'(bus.powerMode), 3);
    checkValue("ackCount", 32'(bus.modeChangeCount), 1);
    checkValue("ackReqDrop", 32'(bus.changeRequest), 0);
    for (int i = 0; i < 16; i++) begin
      checkValue("holdDwell", 32'(bus.controllerState), 2);
      step(1);
    end
    checkValue("holdExit", 32'(bus.controllerState), 0);

    // Low confidence is ignored
    doReset();
    bus.classificationValid = 1'b1;
    bus.workloadFormat = 3'd1;
    bus.workloadConfidence = 4'd5;
    reqCycles = 0;
    step(200);
    checkValue("lowConfReqCycles", 32'(reqCycles), 0);
    checkValue("lowConfMode", 32'(bus.powerMode), 2);

    // Confidence exactly at threshold acts: IDLE goes to SLEEP
    bus.workloadFormat = 3'd5;
    bus.workloadConfidence = 4'd6;
    expReq.push_back(2'd0);
    expMode.push_back(2'd0);
    step(3);
    checkValue("idleNoReqAfter3", 32'(bus.changeRequest), 0);
    step(1);
    checkValue("idleReq", 32'(bus.changeRequest), 1);
    bus.changeAck = 1'b1;
    step(1);
    bus.changeAck = 1'b0;
    checkValue("idleMode", 32'(bus.powerMode), 0);

    // Alternating classifications never agree long enough
    doReset();
    bus.classificationValid = 1'b1;
    bus.workloadConfidence = 4'd8;
    reqCycles = 0;
    for (int i = 0; i < 20; i++) begin
      bus.workloadFormat = (i % 2 == 0) ? 3'd1 : 3'd5;
      step(2);
    end
    checkValue("altReqCycles", 32'(reqCycles), 0);
    checkValue("altMode", 32'(bus.powerMode), 2);

    // Throttle override from PERF while in HOLD
    doReset();
    bus.classificationValid = 1'b1;
    bus.workloadFormat = 3'd1;
    bus.workloadConfidence = 4'd8;
    expReq.push_back(2'd3);
    expMode.push_back(2'd3);
    step(4);
    bus.changeAck = 1'b1;
    step(1);
    bus.changeAck = 1'b0;
    checkValue("perfMode", 32'(bus.powerMode), 3);
    bus.currentPower = 8'd200;
    step(2);
    checkValue("equalNoThrottle", 32'(bus.throttleActive), 0);
    checkValue("equalStillHold", 32'(bus.controllerState), 2);
    bus.currentPower = 8'd220;
    expReq.push_back(2'd1);
    expMode.push_back(2'd1);
    step(1);
    checkValue("throttleSet", 32'(bus.throttleActive), 1);
    checkValue("throttleNoReqYet", 32'(bus.changeRequest), 0);
    step(1);
    checkValue("throttleReq", 32'(bus.changeRequest), 1);
    checkValue("throttleReqMode", 32'(bus.requestedMode), 1);
    bus.changeAck = 1'b1;
    step(1);
    bus.changeAck = 1'b0;
    checkValue("throttleMode", 32'(bus.powerMode), 1);
    checkValue("throttleCount", 32'(bus.modeChangeCount), 2);
    bus.currentPower = 8'd50;

    // Handshake timeout
    doReset();
    bus.classificationValid = 1'b1;
    bus.workloadFormat = 3'd1;
    bus.workloadConfidence = 4'd8;
    expReq.push_back(2'd3);
    step(4);
    checkValue("toReqUp", 32'(bus.changeRequest), 1);
    step(63);
    checkValue("toReqStill", 32'(bus.changeRequest), 1);
    checkValue("toNoPulseYet", 32'(bus.requestTimeout), 0);
    step(1);
    checkValue("toReqDrop", 32'(bus.changeRequest), 0);
    checkValue("toPulse", 32'(bus.requestTimeout), 1);
    checkValue("toMode", 32'(bus.powerMode), 2);
    checkValue("toCount", 32'(bus.modeChangeCount), 0);
    checkValue("toState", 32'(bus.controllerState), 2);
    step(1);
    checkValue("toPulseEnd", 32'(bus.requestTimeout), 0);

    // Reset during REQUEST, stray ack afterwards is ignored
    doReset();
    bus.classificationValid = 1'b1;
    bus.workloadFormat = 3'd1;
    bus.workloadConfidence = 4'd8;
    expReq.push_back(2'd3);
    step(5);
    checkValue("preRstReq", 32'(bus.changeRequest), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    bus.classificationValid = 1'b0;
    checkValue("midRstReq", 32'(bus.changeRequest), 0);
    checkValue("midRstMode", 32'(bus.powerMode), 2);
    checkValue("midRstCount", 32'(bus.modeChangeCount), 0);
    checkValue("midRstState", 32'(bus.controllerState), 0);
    bus.changeAck = 1'b1;
    step(1);
    bus.changeAck = 1'b0;
    step(2);
    checkValue("strayAckMode", 32'(bus.powerMode), 2);
    checkValue("strayAckCount", 32'(bus.modeChangeCount), 0);
    checkValue("strayAckState", 32'(bus.controllerState), 0);

    checkValue("expReqDrained", 32'(expReq.size()), 0);
    checkValue("expModeDrained", 32'(expMode.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
